// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The opcode/funct pair is latched when the fetch completes, and every
// datapath control is then decoded from those latched copies. Outputs are
// combinational from the current state, the latched instruction, zero and
// mem_ready. While rst is high every output, including state, reads 0.
// Optional feature macro: CTRL_SLTI_EN (decodes opcode 001010 as slti).
module mips_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [2:0] alu_control,
  output logic       slt,
  output logic       illegal_instr,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_ADDB = 6'b110000;

  // Decoded view of one instruction; legal=0 means it must trap in DECODE.
  typedef struct packed {
    logic       legal;
    logic [2:0] alu;
    logic       src;
    logic       slt;
    logic       rdst;
  } dec_t;

  // Pure decode of an opcode/funct pair into ALU selects and legality.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.legal = 1'b1;
        d.src   = 1'b1;
        d.rdst  = 1'b1;
        case (fn)
          FN_ADD:  d.alu = 3'b000;
          FN_SUB:  d.alu = 3'b001;
          FN_AND:  d.alu = 3'b010;
          FN_SLL:  d.alu = 3'b011;
          FN_SRL:  d.alu = 3'b100;
          FN_SRA:  d.alu = 3'b101;
          FN_SLT:  begin d.alu = 3'b110; d.slt = 1'b1; end
          FN_ADDB: d.alu = 3'b111;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: d.legal = 1'b1;
      OP_BEQ: begin
        d.legal = 1'b1;
        d.alu   = 3'b001;
        d.src   = 1'b1;
      end
      OP_J: d.legal = 1'b1;
`ifdef CTRL_SLTI_EN
      OP_SLTI: begin
        d.legal = 1'b1;
        d.alu   = 3'b110;
        d.slt   = 1'b1;
      end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t     cur;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  dec_t       dec;

  assign dec = decode(op_q, fn_q);

  // State register and instruction latch; reset wins over mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= FETCH;
      op_q <= 6'd0;
      fn_q <= 6'd0;
    end else begin
      case (cur)
        FETCH: begin
          if (mem_ready) begin
            op_q <= opcode;
            fn_q <= funct;
            cur  <= DECODE;
          end
        end
        DECODE: cur <= dec.legal ? EXEC : FETCH;
        EXEC: begin
          case (op_q)
            OP_LW, OP_SW:  cur <= MEM;
            OP_BEQ, OP_J:  cur <= FETCH;
            default:       cur <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            cur <= (op_q == OP_SW) ? FETCH : WB;
          end
        end
        WB:      cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  // Output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_control   = 3'b000;
    slt           = 1'b0;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    state         = 3'd0;
    if (rst) begin
      state = 3'd0;
    end else begin
      state = cur;
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            ir_write = 1'b0;
            pc_write = 1'b0;
          end
        end
        DECODE: illegal_instr = ~dec.legal;
        EXEC: begin
          alu_control = dec.alu;
          alu_src     = dec.src;
          slt         = dec.slt;
          reg_dst     = dec.rdst;
          case (op_q)
            OP_BEQ: begin
              pc_write   = zero;
              instr_done = 1'b1;
            end
            OP_J: begin
              pc_write   = 1'b1;
              instr_done = 1'b1;
            end
            default: instr_done = 1'b0;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_q == OP_SW);
          if (mem_ready && (op_q == OP_SW)) begin
            instr_done = 1'b1;
          end else begin
            instr_done = 1'b0;
          end
        end
        WB: begin
          alu_control = dec.alu;
          alu_src     = dec.src;
          slt         = dec.slt;
          reg_dst     = dec.rdst;
          reg_write   = 1'b1;
          mem_to_reg  = (op_q == OP_LW);
          instr_done  = 1'b1;
        end
        default: state = cur;
      endcase
    end
  end

endmodule
